// File: rtl/cordic_prerotate.sv
`default_nettype none
// ============================================================================
// Module      : cordic_prerotate
// Description : Angle-reduction front end for cordic_rotation. Takes a vector
//               (x, y) and an arbitrary angle alpha in degrees (signed QN.M)
//               and produces an equivalent rotation request with the angle
//               reduced to [-90, +90]. A 180-degree fold is compensated by
//               negating x and y with saturation.
//               Three registered stages (wrap, fold, apply) with a
//               valid/ready handshake on both sides.
// Ports       : i_clk    - clock, rising edge
//               i_reset  - asynchronous reset, active low
//               i_valid  - upstream sample valid
//               o_ready  - block accepts a sample this cycle
//               i_x/i_y  - input vector, signed QN.M
//               i_alpha  - input angle in degrees, signed QN.M
//               o_valid  - output sample valid (drives cordic i_en)
//               i_ready  - downstream accepts (tie high for cordic_rotation)
//               o_x/o_y  - conditioned vector
//               o_alpha  - reduced angle in [-90, +90]
//               o_flip   - 1 when x and y were negated by the 180 fold
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_prerotate #(
  parameter int N = 9,   // integer bits incl. sign; must be >= 9 to hold 180
  parameter int M = 23   // fractional bits
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [N+M-1:0]   i_x,
  input  logic [N+M-1:0]   i_y,
  input  logic [N+M-1:0]   i_alpha,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [N+M-1:0]   o_x,
  output logic [N+M-1:0]   o_y,
  output logic [N+M-1:0]   o_alpha,
  output logic             o_flip
);

  localparam int W = N + M;

  // Angle constants scaled by 2^M; one extra bit so 360 is representable.
  localparam logic signed [W:0] c_deg90  = (W+1)'(90)  << M;
  localparam logic signed [W:0] c_deg180 = (W+1)'(180) << M;
  localparam logic signed [W:0] c_deg360 = (W+1)'(360) << M;

  // Saturation limits for the negation in the apply stage.
  localparam logic [W-1:0] c_most_neg = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] c_most_pos = {1'b0, {(W-1){1'b1}}};

  // Stage 1 (wrap) registers
  logic                 r_valid1;
  logic [W-1:0]         r_x1;
  logic [W-1:0]         r_y1;
  logic signed [W:0]    r_a1;

  // Stage 2 (fold) registers
  logic                 r_valid2;
  logic [W-1:0]         r_x2;
  logic [W-1:0]         r_y2;
  logic signed [W-1:0]  r_a2;
  logic                 r_flip2;

  // Stage 3 (apply) registers, drive the outputs directly
  logic                 r_valid3;
  logic [W-1:0]         r_x3;
  logic [W-1:0]         r_y3;
  logic [W-1:0]         r_a3;
  logic                 r_flip3;

  logic                 w_advance;
  logic signed [W:0]    w_alpha_ext;
  logic signed [W:0]    w_wrap;
  logic [W-1:0]         w_neg_x;
  logic [W-1:0]         w_neg_y;

  // The whole pipeline moves in lockstep: it advances whenever the output
  // register is empty or being consumed, so bubbles collapse naturally.
  assign w_advance = i_ready | ~r_valid3;
  assign o_ready   = w_advance;

  // Wrap alpha into [-180, 180). Input range is [-256, 256), so a single
  // +/-360 correction is always enough.
  assign w_alpha_ext = {i_alpha[W-1], i_alpha};

  always_comb begin
    w_wrap = w_alpha_ext;
    if (w_alpha_ext >= c_deg180) begin
      w_wrap = w_alpha_ext - c_deg360;
    end else if (w_alpha_ext < -c_deg180) begin
      w_wrap = w_alpha_ext + c_deg360;
    end
  end

  // Saturating negation: the most negative code has no positive twin.
  assign w_neg_x = (r_x2 == c_most_neg) ? c_most_pos : (~r_x2 + 1'b1);
  assign w_neg_y = (r_y2 == c_most_neg) ? c_most_pos : (~r_y2 + 1'b1);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_valid1 <= 1'b0;
      r_x1     <= '0;
      r_y1     <= '0;
      r_a1     <= '0;
    end else if (w_advance) begin
      r_valid1 <= i_valid;
      r_x1     <= i_x;
      r_y1     <= i_y;
      r_a1     <= w_wrap;
    end
  end

  // Fold [-180, 180) into [-90, 90]. The folded result always fits in W bits,
  // so the narrowing here is lossless. Exactly +/-90 is left alone; -180 folds
  // to 0 with the flip set.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_valid2 <= 1'b0;
      r_x2     <= '0;
      r_y2     <= '0;
      r_a2     <= '0;
      r_flip2  <= 1'b0;
    end else if (w_advance) begin
      r_valid2 <= r_valid1;
      r_x2     <= r_x1;
      r_y2     <= r_y1;
      if (r_a1 > c_deg90) begin
        r_a2    <= W'(r_a1 - c_deg180);
        r_flip2 <= 1'b1;
      end else if (r_a1 < -c_deg90) begin
        r_a2    <= W'(r_a1 + c_deg180);
        r_flip2 <= 1'b1;
      end else begin
        r_a2    <= W'(r_a1);
        r_flip2 <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_valid3 <= 1'b0;
      r_x3     <= '0;
      r_y3     <= '0;
      r_a3     <= '0;
      r_flip3  <= 1'b0;
    end else if (w_advance) begin
      r_valid3 <= r_valid2;
      r_x3     <= r_flip2 ? w_neg_x : r_x2;
      r_y3     <= r_flip2 ? w_neg_y : r_y2;
      r_a3     <= r_a2;
      r_flip3  <= r_flip2;
    end
  end

  assign o_valid = r_valid3;
  assign o_x     = r_x3;
  assign o_y     = r_y3;
  assign o_alpha = r_a3;
  assign o_flip  = r_flip3;

endmodule
`default_nettype wire

// File: tb/tb_cordic_prerotate.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_prerotate
// Description : Self-checking bench for cordic_prerotate. Expected results are
//               queued when an input transfer happens and compared in order
//               when an output transfer happens.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_prerotate;

  localparam int N = 9;
  localparam int M = 23;
  localparam int W = N + M;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] a;
    logic         f;
  } exp_t;

  logic         i_clk = 1'b0;
  logic         i_reset;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_x;
  logic [W-1:0] i_y;
  logic [W-1:0] i_alpha;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_x;
  logic [W-1:0] o_y;
  logic [W-1:0] o_alpha;
  logic         o_flip;

  int    n_tests = 0;
  int    n_fail  = 0;
  exp_t  q[$];
  exp_t  pend;
  string tname = "none";

  cordic_prerotate #(.N(N), .M(M)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_x     (i_x),
    .i_y     (i_y),
    .i_alpha (i_alpha),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_x     (o_x),
    .o_y     (o_y),
    .o_alpha (o_alpha),
    .o_flip  (o_flip)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [W-1:0] deg(int d);
    longint v;
    v = longint'(d) * (longint'(1) << M);
    return v[W-1:0];
  endfunction

  // Reference model written from the angle-reduction rules.
  function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic [W-1:0] al);
    exp_t   e;
    longint a;
    longint d90;
    d90 = longint'(90) * (longint'(1) << M);
    a   = longint'($signed(al));
    if (a >= 2 * d90)       a = a - 4 * d90;
    else if (a < -2 * d90)  a = a + 4 * d90;
    e.f = 1'b0;
    if (a > d90)            begin a = a - 2 * d90; e.f = 1'b1; end
    else if (a < -d90)      begin a = a + 2 * d90; e.f = 1'b1; end
    e.a = a[W-1:0];
    if (e.f) begin
      e.x = (x == 32'h8000_0000) ? 32'h7FFF_FFFF : 32'(-$signed(x));
      e.y = (y == 32'h8000_0000) ? 32'h7FFF_FFFF : 32'(-$signed(y));
    end else begin
      e.x = x;
      e.y = y;
    end
    return e;
  endfunction

  task automatic set_in(logic [W-1:0] x, logic [W-1:0] y, logic [W-1:0] a, exp_t e);
    i_valid = 1'b1;
    i_x     = x;
    i_y     = y;
    i_alpha = a;
    pend    = e;
  endtask

  // One clock: decide both transfers from the settled signals before the
  // edge, score any output, queue any input, then return just after the edge.
  task automatic tick(output bit in_x, output bit out_x);
    exp_t e;
    @(negedge i_clk);
    in_x  = i_valid && o_ready;
    out_x = o_valid && i_ready;
    if (out_x) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL %s unexpected_output: got x=%h y=%h a=%h f=%b, required no output",
                 tname, o_x, o_y, o_alpha, o_flip);
      end else begin
        e = q.pop_front();
        if ({o_x, o_y, o_alpha, o_flip} !== e) begin
          n_fail++;
          $display("FAIL %s output: got x=%h y=%h a=%h f=%b, required x=%h y=%h a=%h f=%b",
                   tname, o_x, o_y, o_alpha, o_flip, e.x, e.y, e.a, e.f);
        end
      end
    end
    if (in_x) q.push_back(pend);
    @(posedge i_clk);
    #1;
  endtask

  task automatic drain(int budget);
    bit ix, ox;
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < budget && q.size() != 0; k++) tick(ix, ox);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain: got %0d pending, required 0", tname, q.size());
    end
  endtask

  task automatic test_reset();
    tname   = "reset";
    i_reset = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_x = '0; i_y = '0; i_alpha = '0;
    @(posedge i_clk);
    #1;
    n_tests++;
    if ({o_valid, o_x, o_y, o_alpha, o_flip} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b x=%h y=%h a=%h f=%b, required all 0",
               o_valid, o_x, o_y, o_alpha, o_flip);
    end
    @(negedge i_clk);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    n_tests++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got ready=%b valid=%b, required ready=1 valid=0", o_ready, o_valid);
    end
  endtask

  task automatic test_basic();
    bit ix, ox;
    int first = -1;
    int seen  = 0;
    tname = "basic";
    set_in(deg(1), deg(1), deg(90), '{x: deg(1), y: deg(1), a: deg(90), f: 1'b0});
    tick(ix, ox);
    n_tests++;
    if (!ix) begin
      n_fail++;
      $display("FAIL basic_accept: got transfer=%b, required 1", ix);
    end
    i_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick(ix, ox);
      if (ox) begin
        seen++;
        if (first < 0) first = k;
      end
    end
    n_tests++;
    if (first != 3 || seen != 1) begin
      n_fail++;
      $display("FAIL basic_latency: got first=%0d count=%0d, required first=3 count=1", first, seen);
    end
  endtask

  task automatic test_fold_wrap();
    bit ix, ox;
    logic [W-1:0] ax[16], ex[16], ey[16], xa[16], ya[16], ea[16];
    logic         ef[16];
    int           n = 0;
    int           sent = 0;
    int           in_deg[11]  = '{135, -200, 250, -180, -90, 91, -91, 179, 180, -181, 0};
    int           out_deg[11] = '{-45, -20,  70,  0,   -90, -89, 89, -1,  0,   -1,   0};
    logic         out_f[11]   = '{1,   1,    1,   1,    0,   1,   1,   1,   1,    1,   0};
    tname = "fold_wrap";
    for (int k = 0; k < 11; k++) begin
      ax[n] = deg(in_deg[k]); xa[n] = deg(1); ya[n] = deg(1);
      ea[n] = deg(out_deg[k]); ef[n] = out_f[k];
      ex[n] = out_f[k] ? 32'hFF80_0000 : deg(1);
      ey[n] = ex[n];
      n++;
    end
    // Saturating negation corners
    xa[n] = 32'h8000_0000; ya[n] = 32'h0080_0000; ax[n] = deg(180);
    ex[n] = 32'h7FFF_FFFF; ey[n] = 32'hFF80_0000; ea[n] = '0; ef[n] = 1'b1; n++;
    xa[n] = 32'h7FFF_FFFF; ya[n] = 32'h8000_0000; ax[n] = deg(-180);
    ex[n] = 32'h8000_0001; ey[n] = 32'h7FFF_FFFF; ea[n] = '0; ef[n] = 1'b1; n++;
    // Extremes of the alpha range
    xa[n] = 32'h0000_1234; ya[n] = 32'h0000_0000; ax[n] = 32'h8000_0000;
    ex[n] = 32'hFFFF_EDCC; ey[n] = 32'h0000_0000; ea[n] = deg(-76); ef[n] = 1'b1; n++;
    xa[n] = 32'h0000_0005; ya[n] = 32'hFFFF_FFFB; ax[n] = 32'h7FFF_FFFF;
    ex[n] = 32'hFFFF_FFFB; ey[n] = 32'h0000_0005; ea[n] = deg(76) - 1; ef[n] = 1'b1; n++;
    i_ready = 1'b1;
    for (int c = 0; c < 40 && sent < n; c++) begin
      set_in(xa[sent], ya[sent], ax[sent],
             '{x: ex[sent], y: ey[sent], a: ea[sent], f: ef[sent]});
      tick(ix, ox);
      if (ix) sent++;
    end
    drain(10);
  endtask

  task automatic test_back_to_back();
    bit   ix, ox;
    int   sent = 0;
    int   got  = 0;
    logic sv, sr, sf;
    logic [W-1:0] sx, sy, sa, x, y, a;
    tname = "back_to_back";
    for (int c = 0; c < 40 && got < 8; c++) begin
      i_ready = !(c >= 4 && c <= 7);
      if (sent < 8) begin
        x = 32'(sent + 1) << 20;
        y = ~x;
        a = deg(47 * sent - 170) + 32'(sent);
        set_in(x, y, a, model(x, y, a));
      end else begin
        i_valid = 1'b0;
      end
      #1;
      if (o_valid && !i_ready) begin
        n_tests++;
        if (o_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL back_to_back_ready c=%0d: got o_ready=%b, required 0", c, o_ready);
        end
      end
      sv = o_valid; sr = i_ready; sx = o_x; sy = o_y; sa = o_alpha; sf = o_flip;
      tick(ix, ox);
      if (ix) sent++;
      if (ox) got++;
      if (sv && !sr) begin
        n_tests++;
        if ({o_valid, o_x, o_y, o_alpha, o_flip} !== {1'b1, sx, sy, sa, sf}) begin
          n_fail++;
          $display("FAIL back_to_back_stable c=%0d: got v=%b x=%h a=%h, required v=1 x=%h a=%h",
                   c, o_valid, o_x, o_alpha, sx, sa);
        end
      end
    end
    n_tests++;
    if (got != 8 || q.size() != 0) begin
      n_fail++;
      $display("FAIL back_to_back_count: got %0d outputs %0d pending, required 8 outputs 0 pending",
               got, q.size());
    end
  endtask

  task automatic test_random();
    bit ix, ox;
    int sent = 0;
    logic [W-1:0] x, y, a;
    tname = "random";
    x = $urandom; y = $urandom; a = $urandom;
    for (int c = 0; c < 300 && sent < 32; c++) begin
      i_ready = ($urandom_range(0, 3) != 0);
      set_in(x, y, a, model(x, y, a));
      tick(ix, ox);
      if (ix) begin
        sent++;
        x = $urandom; y = $urandom; a = $urandom;
      end
    end
    drain(20);
  endtask

  task automatic test_reset_midflight();
    bit ix, ox;
    int seen = 0;
    tname   = "reset_midflight";
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_in(deg(k + 2), deg(-k - 2), deg(30 * k), model(deg(k + 2), deg(-k - 2), deg(30 * k)));
      tick(ix, ox);
    end
    i_valid = 1'b0;
    n_tests++;
    if (o_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_midflight_pre: got o_valid=%b, required 1", o_valid);
    end
    #2 i_reset = 1'b0;
    #1;
    n_tests++;
    if ({o_valid, o_x, o_y, o_alpha, o_flip} !== '0) begin
      n_fail++;
      $display("FAIL reset_midflight_async: got v=%b x=%h a=%h f=%b, required all 0",
               o_valid, o_x, o_alpha, o_flip);
    end
    q.delete();
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    n_tests++;
    if (o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_midflight_ready: got o_ready=%b, required 1", o_ready);
    end
    @(posedge i_clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      tick(ix, ox);
      if (ox) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_midflight_stale: got %0d outputs, required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fold_wrap();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached in %s", tname);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
